// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Serial line input and received-byte outputs of uart_rx.
//                master = the receiver, slave = the pin driver / consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output data,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Samples mid-bit from a synchronized rx,
//                strobes valid for each good byte, frame_err for a low stop
//                bit, and waits for the line to return high after an error.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.master bus
);

  localparam int BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_DIVISOR = BAUD_DIVISOR / 2;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIVISOR - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_DIVISOR - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_rx_meta;
  logic        r_rx_s;
  logic        r_rx_s_d;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift_reg;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err;
  logic        r_busy;
  logic        w_fall;

  // Two-flop synchronizer for the asynchronous pin plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_s_d  <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
      r_rx_s_d  <= r_rx_s;
    end
  end

  assign w_fall = r_rx_s_d & ~r_rx_s;

  // Frame state machine: mid-bit sampling, byte assembly and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_baud_cnt  <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shift_reg <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state    <= S_START;
            r_baud_cnt <= 16'd0;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          if (r_baud_cnt == HALF_LAST) begin
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            if (!r_rx_s) begin
              r_state <= S_DATA;
            end else begin
              // Line was high again at mid start bit: treat as a glitch
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt             <= 16'd0;
            r_shift_reg[r_bit_idx] <= r_rx_s;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= 16'd0;
            if (r_rx_s) begin
              r_data  <= r_shift_reg;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        S_WAIT_HIGH: begin
          // Hold off until the line idles so a break is not read as start bits
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire
